// File: rtl/mux_sel_sequencer.sv
// Round-robin sel1/sel2 generator for mux4to1: grants one of four requesters for up to DWELL cycles.
// Optional MUX_SEQ_STATS_EN adds a saturating 16-bit grant_total counter port.
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic       done,
  output logic       sel1,
  output logic       sel2,
  output logic       valid,
`ifdef MUX_SEQ_STATS_EN
  output logic [15:0] grant_total,
`endif
  output logic [3:0] grant
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_n;
  logic [1:0]       sel_q, sel_n;
  logic             valid_q, valid_n;
  logic [3:0]       grant_q, grant_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       ptr_q, ptr_n;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             issue;

  // Search starts one past the last-served channel so it is considered last.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    valid_n = valid_q;
    grant_n = grant_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && found) issue = 1'b1;
      end
      GRANT: begin
        if (done || cnt_q == '0) begin
          if (enable && found) begin
            issue = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            grant_n = '0;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) begin
      state_n = GRANT;
      sel_n   = win;
      grant_n = 4'b0001 << win;
      valid_n = 1'b1;
      cnt_n   = CNT_LOAD;
      ptr_n   = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      valid_q <= valid_n;
      grant_q <= grant_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
    end
  end

`ifdef MUX_SEQ_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else if (issue && total_q != '1) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign grant_total = total_q;
`endif

  assign sel1  = sel_q[1];
  assign sel2  = sel_q[0];
  assign valid = valid_q;
  assign grant = grant_q;

endmodule
